// File: rtl/lzw_uart_tx_if.sv
// Byte handshake between the LZW core (master) and the serial transmitter (slave).
interface lzw_uart_tx_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/lzw_uart_tx.sv
// Buffered 8N1 serial transmitter for LZW output bytes: FIFO plus a baud-timed frame FSM.
// Defining LZW_UART_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module lzw_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic             clk,
    input  logic             rst,
    lzw_uart_tx_if.slave     bus,
    output logic             sout,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam int                 BW         = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]      BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef LZW_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    // Ready comes from the registered count only, so a pop in the same cycle never opens a full FIFO.
    assign bus.din_ready = (fifo_count != COUNT_FULL);
    assign push          = bus.din_valid & bus.din_ready;
    assign head          = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------- frame FSM
    state_t        state,    state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx,  idx_n;
    logic [7:0]    shift,    shift_n;
    logic          sout_n;
    logic          baud_done;
    logic          have_byte;
`ifdef LZW_UART_PARITY_EN
    logic          par_bit,  par_n;
`endif

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign have_byte = (fifo_count != '0);
    assign tx_busy   = (state != IDLE) | have_byte;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_n = state;
        baud_n  = baud_cnt;
        idx_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        sout_n  = 1'b1;
`ifdef LZW_UART_PARITY_EN
        par_n   = par_bit;
`endif

        case (state)
            IDLE: begin
                if (have_byte) begin
                    pop     = 1'b1;
                    shift_n = head;
`ifdef LZW_UART_PARITY_EN
                    par_n   = ^head;
`endif
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) begin
`ifdef LZW_UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef LZW_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    // Another byte waiting: chain straight into its start bit with no idle gap.
                    if (have_byte) begin
                        pop     = 1'b1;
                        shift_n = head;
`ifdef LZW_UART_PARITY_EN
                        par_n   = ^head;
`endif
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // sout is registered, so it is decoded from the state being entered.
        case (state_n)
            START:   sout_n = 1'b0;
            DATA:    sout_n = shift_n[0];
`ifdef LZW_UART_PARITY_EN
            PARITY:  sout_n = par_n;
`endif
            default: sout_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            sout     <= 1'b1;
`ifdef LZW_UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= idx_n;
            shift    <= shift_n;
            sout     <= sout_n;
`ifdef LZW_UART_PARITY_EN
            par_bit  <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_lzw_uart_tx.sv
// Self-checking bench for lzw_uart_tx: vector table, hand-written corner sequences, random stream vs. scoreboard.
module tb_lzw_uart_tx;

    localparam int C  = 4;
    localparam int AW = 2;
`ifdef LZW_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sout;
    logic          tx_busy;
    logic [AW:0]   fifo_count;

    lzw_uart_tx_if bus();

    lzw_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sout       (sout),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired (cycle %0d)", name, cyc);
    endtask

    // Line monitor: an ideal receiver that samples every bit in its middle.
    typedef struct {
        logic [FB-1:0] bits;
        int            start;
    } rx_t;

    rx_t rx_q[$];
    int  n_starts = 0;

    always begin
        @(negedge clk);
        if (sout === 1'b0) begin
            rx_t r;
            r.start  = cyc;
            r.bits   = '0;
            n_starts = n_starts + 1;
            repeat (C / 2) @(negedge clk);
            r.bits[0] = sout;
            for (int b = 1; b < FB; b++) begin
                repeat (C) @(negedge clk);
                r.bits[b] = sout;
            end
            rx_q.push_back(r);
        end
    end

    logic [7:0] sb_q[$];
    int         push_edge = 0;

    // Called at a negedge; holds valid until the byte is taken, returns at the next negedge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        bus.din       = b;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.din_ready) begin
            timeout("push_wait");
        end else begin
            sb_q.push_back(b);
            push_edge = cyc + 1;
        end
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string name);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rx_q.size() < n) timeout(name);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (tx_busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (tx_busy !== 1'b0) timeout(name);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_frames"}, rx_q.size(), sb_q.size());
        for (int i = 0; i < rx_q.size() && i < sb_q.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), rx_q[i].bits[8:1], sb_q[i]);
            check($sformatf("%s_framing%0d", name, i), {rx_q[i].bits[FB-1], rx_q[i].bits[0]}, 2'b10);
`ifdef LZW_UART_PARITY_EN
            check($sformatf("%s_parity%0d", name, i), rx_q[i].bits[9], ^sb_q[i]);
`endif
        end
    endtask

    // Table: byte and its 10-bit 8N1 line image (bit i = i-th bit on the wire), plus even parity.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [FB-1:0] full_frame(input vec_t v);
`ifdef LZW_UART_PARITY_EN
        return {v.frame[9], v.par, v.frame[8:0]};
`else
        return v.frame;
`endif
    endfunction

    initial begin
        int s;
        int s1;
        int p0;
        int starts_after_rst;

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
        vecs[3] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
        vecs[4] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
        vecs[5] = '{8'h03, 10'b1_0000_0011_0, 1'b0};
        vecs[6] = '{8'h81, 10'b1_1000_0001_0, 1'b0};
        vecs[7] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
        vecs[8] = '{8'h01, 10'b1_0000_0001_0, 1'b1};
        vecs[9] = '{8'h6E, 10'b1_0110_1110_0, 1'b1};

        bus.din       = '0;
        bus.din_valid = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_after_reset", {sout, bus.din_ready, tx_busy, fifo_count}, {1'b1, 1'b1, 1'b0, 3'd0});
        end

        // Single bytes from the table: line image, start latency, busy release at frame end.
        for (int i = 0; i < 10; i++) begin
            rx_q.delete();
            sb_q.delete();
            push_byte(vecs[i].data);
            s = push_edge + 1;
            wait_cycle(s + FL - 1);
            check($sformatf("tbl%0d_busy_last", i), tx_busy, 1'b1);
            @(negedge clk);
            check($sformatf("tbl%0d_busy_drop", i), tx_busy, 1'b0);
            wait_rx(1, "tbl_rx");
            if (rx_q.size() >= 1) begin
                check($sformatf("tbl%0d_bits", i), rx_q[0].bits, full_frame(vecs[i]));
                check($sformatf("tbl%0d_latency", i), rx_q[0].start, s);
            end
        end

        // Back-to-back: three contiguous frames.
        rx_q.delete();
        sb_q.delete();
        push_byte(8'h00);
        p0 = push_edge;
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_cycle(p0 + 1 + 3 * FL - 1);
        check("b2b_busy_last", tx_busy, 1'b1);
        @(negedge clk);
        check("b2b_busy_drop", tx_busy, 1'b0);
        wait_rx(3, "b2b_rx");
        if (rx_q.size() >= 3) begin
            check("b2b_start0", rx_q[0].start, p0 + 1);
            check("b2b_start1", rx_q[1].start, p0 + 1 + FL);
            check("b2b_start2", rx_q[2].start, p0 + 1 + 2 * FL);
            check("b2b_bits0", rx_q[0].bits, full_frame(vecs[1]));
            check("b2b_bits1", rx_q[1].bits, full_frame(vecs[2]));
            check("b2b_bits2", rx_q[2].bits, full_frame(vecs[3]));
        end

        // Full FIFO back-pressure: sixth byte waits for the first pop.
        rx_q.delete();
        sb_q.delete();
        push_byte(8'h11);
        s1 = push_edge + 1;
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_byte(8'h55);
        bus.din       = 8'h66;
        bus.din_valid = 1'b1;
        check("full_ready", bus.din_ready, 1'b0);
        check("full_count", fifo_count, 3'd4);
        check("full_busy", tx_busy, 1'b1);
        push_byte(8'h66);
        check("full_release_edge", push_edge, s1 + FL + 1);
        wait_rx(6, "full_rx");
        wait_idle("full_idle");
        repeat (2 * FL) @(negedge clk);
        compare_stream("full");
        if (rx_q.size() >= 1) check("full_first_start", rx_q[0].start, s1);

        // Reset in the middle of a data bit abandons the frame and empties the FIFO.
        rx_q.delete();
        sb_q.delete();
        push_byte(8'h81);
        s = push_edge + 1;
        push_byte(8'h3C);
        wait_cycle(s + 3 * C + 1);
        check("pre_rst_count", fifo_count, 3'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_sout", sout, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ready", bus.din_ready, 1'b1);
        starts_after_rst = n_starts;
        for (int i = 0; i < 12 * C; i++) begin
            @(negedge clk);
            check("rst_quiet_sout", sout, 1'b1);
        end
        check("rst_no_new_frames", n_starts, starts_after_rst);
        rx_q.delete();
        sb_q.delete();
        push_byte(8'h55);
        s = push_edge + 1;
        wait_rx(1, "post_rst_rx");
        if (rx_q.size() >= 1) begin
            check("post_rst_bits", rx_q[0].bits, full_frame(vecs[7]));
            check("post_rst_latency", rx_q[0].start, s);
        end
        wait_idle("post_rst_idle");

        // Random stream with random gaps, checked against the scoreboard.
        rx_q.delete();
        sb_q.delete();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) repeat (50) @(negedge clk);
            else repeat ($urandom_range(0, 3)) @(negedge clk);
            push_byte(8'($urandom));
        end
        wait_rx(40, "rand_rx");
        wait_idle("rand_idle");
        repeat (2 * FL) @(negedge clk);
        compare_stream("rand");
        check("end_state", {sout, bus.din_ready, tx_busy, fifo_count}, {1'b1, 1'b1, 1'b0, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzw_uart_tx.md
Name: lzw_uart_tx

Overview:
- FPGA-side serial transmitter that sends compressed LZW output bytes to the host serial line.
- Accepts bytes from the LZW core over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as an 8N1 frame (start 0, 8 data bits LSB first, stop 1) at a fixed baud rate derived from the system clock.
- sout drives the host-side serial model's sin; at the default settings the rate is 115200 baud.

Parameters:
- CLKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  8  byte from the LZW core.
- din_valid  input  1  din holds a valid byte.
- din_ready  output  1  FIFO can accept a byte this cycle.
- sout  output  1  serial data out; idles high.
- tx_busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_count  output  FIFO_AW+1  number of bytes held in the FIFO (0..DEPTH).

Behaviour:
- Reset (sampled at a clk edge while rst=1):
  - FIFO emptied; fifo_count=0; din_ready=1.
  - sout=1, tx_busy=0, FSM=IDLE, baud and bit counters cleared.
  - Applies mid-frame: sout returns high at that edge and the partial frame is abandoned, not resumed.
- FIFO:
  - Push occurs when din_valid & din_ready.
  - din_ready = (fifo_count != DEPTH), a registered-count decode. When full, a push is refused even if a pop happens in the same cycle.
  - Pop occurs when the FSM loads a byte.
  - Push and pop in the same cycle leave fifo_count unchanged; data order is preserved.
  - Read/write pointers wrap modulo DEPTH. fifo_count is the exact occupancy; full = DEPTH, not DEPTH-1.
- FSM states:
  - IDLE: sout=1. If fifo_count!=0: pop, load the shift register, clear the baud counter, go to START.
  - START: sout=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
  - DATA: sout = shift[0]; each bit is held CLKS_PER_BIT clocks, then the register shifts right and the index increments. After index 7 completes, go to STOP (or PARITY, see below).
  - STOP: sout=1 for CLKS_PER_BIT clocks. At the end: if fifo_count!=0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Baud counter:
  - Width ceil(log2(CLKS_PER_BIT)), counting 0..CLKS_PER_BIT-1.
  - The terminal count advances the bit; the counter wraps to 0.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE:
  - fifo_count=1 after edge N.
  - Pop at edge N+1; sout falls at edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT clocks.
- sout is driven from a register (glitch-free).
- tx_busy = (state!=IDLE) | (fifo_count!=0).
- din is ignored when din_valid=0. din_valid held with din_ready=0 is not an error; the byte is taken once space frees.

Optional Feature:
- Macro: LZW_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - sout = even parity (XOR of the 8 data bits) for CLKS_PER_BIT clocks.
  - Frame is 11*CLKS_PER_BIT clocks.
- Not defined: no PARITY state and no parity logic; the frame is 10 bits. This is the default and is required for the host serial model, which has no parity.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2 unless noted):
1. Idle after reset -> sout=1, din_ready=1, tx_busy=0, fifo_count=0 for 100 cycles.
2. Push 0xA5 once -> sout falls one edge after the push. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1. tx_busy drops 40 clocks after the frame start.
3. Push 0x00, 0xFF, 0x3C back-to-back -> three contiguous frames with no idle gap between stop and start; total 120 clocks; bytes recovered in order.
4. Hold din_valid high with 6 bytes while the FIFO is full at 4 -> din_ready=0 until the first pop; all 6 bytes transmitted in order; none lost or duplicated.
5. Assert rst mid-DATA of 0x81 for one cycle -> sout=1 on the next edge, fifo_count=0, no further frames; a subsequent push of 0x55 transmits correctly.
6. With LZW_UART_PARITY_EN defined, push 0x07 -> 11-bit frame with parity bit 1 before the stop bit. Push 0x03 -> parity bit 0.
